// File: rtl/edge_threshold.sv
// Binarizes a Sobel edge-magnitude stream against a per-frame threshold.
// After dropping the upstream fill samples it emits one raster-ordered frame and counts the edge pixels.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for start; threshold is latched on start
// FILL  | dropping the first PIPE_DELAY accepted samples
// RUN   | one output per accepted sample, raster order
// DONE  | single cycle; frameDone pulses on the way back to IDLE
`timescale 1ns/1ps
module edge_threshold #(
    parameter int WORD_SIZE   = 8,
    parameter int ROW_SIZE    = 10,
    parameter int NUM_ROWS    = 10,
    parameter int PIPE_DELAY  = 13,
    parameter int BORDER_ZERO = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        inValid,
    input  logic [WORD_SIZE-1:0]        inputPixel,
    input  logic [WORD_SIZE-1:0]        threshold,
    output logic                        outValid,
    output logic [WORD_SIZE-1:0]        outputPixel,
    output logic [$clog2(ROW_SIZE)-1:0] outCol,
    output logic [$clog2(NUM_ROWS)-1:0] outRow,
    output logic                        frameDone,
    output logic [15:0]                 edgeCount
);

    localparam int CW = $clog2(ROW_SIZE);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int FW = $clog2(PIPE_DELAY + 2);
    localparam logic [CW-1:0] COL_LAST  = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_ROWS - 1);
    localparam logic [FW-1:0] FILL_LAST = (PIPE_DELAY > 0) ? FW'(PIPE_DELAY - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [WORD_SIZE-1:0] r_thresh;
    logic [FW-1:0]        r_fill;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic                 r_out_valid;
    logic [WORD_SIZE-1:0] r_out_pixel;
    logic [CW-1:0]        r_out_col;
    logic [RW-1:0]        r_out_row;
    logic                 r_frame_done;
    logic [15:0]          r_edge_cnt;

    logic w_border;
    logic w_edge;

    assign w_border = (BORDER_ZERO != 0) &&
                      ((r_col == '0) || (r_col == COL_LAST) ||
                       (r_row == '0) || (r_row == ROW_LAST));
    assign w_edge   = (inputPixel >= r_thresh) && !w_border;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_thresh     <= '0;
            r_fill       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_out_pixel  <= '0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_frame_done <= 1'b0;
            r_edge_cnt   <= '0;
        end else begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_thresh   <= threshold;
                        r_edge_cnt <= '0;
                        r_fill     <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_state    <= (PIPE_DELAY == 0) ? RUN : FILL;
                    end
                end
                FILL: begin
                    if (inValid) begin
                        r_fill <= r_fill + FW'(1);
                        if (r_fill == FILL_LAST) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (inValid) begin
                        r_out_valid <= 1'b1;
                        r_out_pixel <= {WORD_SIZE{w_edge}};
                        r_out_col   <= r_col;
                        r_out_row   <= r_row;
                        if (w_edge && (r_edge_cnt != 16'hFFFF)) begin
                            r_edge_cnt <= r_edge_cnt + 16'd1;
                        end
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_row   <= '0;
                                r_state <= DONE;
                            end else begin
                                r_row <= r_row + RW'(1);
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                DONE: begin
                    r_frame_done <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign outValid    = r_out_valid;
    assign outputPixel = r_out_pixel;
    assign outCol      = r_out_col;
    assign outRow      = r_out_row;
    assign frameDone   = r_frame_done;
    assign edgeCount   = r_edge_cnt;

endmodule

// File: doc/edge_threshold.md
EDGE_THRESHOLD -- requirements
Module: edge_threshold

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, pixel width of the edge-magnitude stream.
REQ-002 SHALL have parameter ROW_SIZE, default 10, pixels per image row.
REQ-003 SHALL have parameter NUM_ROWS, default 10, rows per frame.
REQ-004 SHALL have parameter PIPE_DELAY, default 13, accepted samples discarded at frame start (upstream fill latency).
REQ-005 SHALL have parameter BORDER_ZERO, default 1, forces first/last row and column outputs to 0 when 1.
REQ-006 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle frame-start request.
REQ-009 SHALL have port inValid  input  1  inputPixel is valid this cycle.
REQ-010 SHALL have port inputPixel  input  WORD_SIZE  Sobel edge magnitude from the upstream stage.
REQ-011 SHALL have port threshold  input  WORD_SIZE  binarization threshold, sampled on accepted start.
REQ-012 SHALL have port outValid  output  1  outputPixel/outCol/outRow valid.
REQ-013 SHALL have port outputPixel  output  WORD_SIZE  binary edge map: 0 or all-ones.
REQ-014 SHALL have port outCol  output  $clog2(ROW_SIZE)  column of outputPixel.
REQ-015 SHALL have port outRow  output  $clog2(NUM_ROWS)  row of outputPixel.
REQ-016 SHALL have port frameDone  output  1  one-cycle end-of-frame pulse.
REQ-017 SHALL have port edgeCount  output  16  number of edge pixels in the current/last frame, saturating at 16'hFFFF.

Function
REQ-018 SHALL implement states IDLE, FILL, RUN, DONE, with all outputs registered.
REQ-019 IDLE: start=1 SHALL latch threshold, clear edgeCount, clear column/row/fill counters, go to FILL (to RUN directly if PIPE_DELAY=0); inValid on that cycle is not consumed.
REQ-020 start while not in IDLE SHALL be ignored; threshold changes after the latch SHALL have no effect until the next accepted start.
REQ-021 FILL: each cycle with inValid=1 SHALL increment the fill counter and drop the sample; on the PIPE_DELAY-th accepted sample go to RUN; outValid stays 0.
REQ-022 RUN: each cycle with inValid=1 SHALL, on that edge, set outValid=1, outCol/outRow to current counters, outputPixel per REQ-023, then advance counters; inValid=0 SHALL give outValid=0 next cycle with counters held.
REQ-023 Pixel rule: edge = (inputPixel >= latched threshold, unsigned); border pixel (col 0, col ROW_SIZE-1, row 0, row NUM_ROWS-1) with BORDER_ZERO=1 SHALL be edge=0; outputPixel = all-ones if edge else 0.
REQ-024 edgeCount SHALL increment by 1 per RUN output with edge=1, holding at 16'hFFFF, and hold its value from DONE until the next accepted start.
REQ-025 Column SHALL wrap ROW_SIZE-1 -> 0 with row increment; output at (NUM_ROWS-1, ROW_SIZE-1) SHALL move state to DONE.
REQ-026 DONE SHALL last exactly one cycle, assert frameDone=1 in that cycle (outValid=0), then return to IDLE.
REQ-027 Per frame exactly ROW_SIZE*NUM_ROWS outputs in raster order SHALL be produced, independent of inValid gaps.
REQ-028 outValid SHALL be 0 in IDLE, FILL and DONE; outputPixel/outCol/outRow hold last values when outValid=0.

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force state IDLE and outValid, outputPixel, outCol, outRow, frameDone, edgeCount, all counters and latched threshold to 0.
REQ-030 Reset in any state, including mid-RUN, SHALL abort the frame with no frameDone; a new frame needs start after reset release.
REQ-031 Release SHALL be synchronised in use: first start accepted on the first rising edge with reset=1.

Verification
REQ-032 Defaults, threshold=128, start, inputPixel=200 every cycle, inValid=1 -> 13 samples dropped, 100 outputs, 64 interior =255, 36 border =0, edgeCount=64, frameDone one cycle after 100th output.
REQ-033 threshold=0, inputPixel=0 constant -> interior outputs 255 (>= rule), edgeCount=64; BORDER_ZERO=0 -> edgeCount=100.
REQ-034 inValid toggling 1,0,1,0 -> outValid only after valid samples, 100 outputs, (row,col) sequence (0,0)..(9,9) unbroken, edgeCount same as REQ-032.
REQ-035 start pulsed at 50th output with threshold changed to 255 -> ignored; frame completes with original results.
REQ-036 reset=0 asserted at 40th output -> outputs 0 same cycle, no frameDone; after release and start, full frame matches REQ-032.
REQ-037 start with PIPE_DELAY=0 -> first accepted sample produces (0,0) output next edge, no FILL cycles.
